alu_nibble_serial_exec: RTL and testbench

- Sequential counterpart to the parallel 4-bit-slice ALU array.
- Accepts one 32-bit operation per valid/ready handshake and executes it on a single 4-bit slice, one nibble per cycle, LSB first.
- Propagates carry/borrow between nibbles, so arithmetic and compare results are full-width correct.
- Returns the reassembled result on an output valid/ready handshake. Used in area-constrained lanes of the superscalar core.

---
 rtl/alu_nibble_serial_exec.sv | 175 +++++++++++++++++
 tb/tb_alu_nibble_serial_exec.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_nibble_serial_exec.sv
// Nibble-serial ALU: accepts one WIDTH-bit op per handshake, executes it
// SLICE bits per cycle LSB first, and returns the result on an output handshake.
//
// Ports:
//   clk, rst_n           - clock, async active-low reset
//   in_valid / in_ready  - request handshake carrying A, B, ALUControl
//   A, B                 - signed operands
//   ALUControl           - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU
//   out_valid / out_ready- result handshake carrying Result, Zero, Err
//   Result, Zero, Err    - result, Result==0, unsupported opcode
module alu_nibble_serial_exec #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Err
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [3:0]       op_q;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             a_msb;
    logic             b_msb;
    logic [WIDTH-1:0] res_q;
    logic             zero_q;
    logic             err_q;

    logic             fire;
    logic             last;
    logic             invert;
    logic [SLICE-1:0] a_nib;
    logic [SLICE-1:0] b_nib;
    logic [SLICE:0]   sum;
    logic [SLICE-1:0] nib_res;
    logic             c_next;
    logic [WIDTH-1:0] sh_next;
    logic             n_bit;
    logic             v_bit;
    logic [WIDTH-1:0] fin;
    logic             fin_err;

    // Subtract-style ops run A + ~B + 1 through the slice.
    function automatic logic is_sub(input logic [3:0] op);
        return (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
    endfunction

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign fire      = in_valid && in_ready;
    assign last      = (state == EXEC) && (cnt == LAST);

    assign Result = res_q;
    assign Zero   = zero_q;
    assign Err    = err_q && out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (fire) state_next = EXEC;
            EXEC: if (cnt == LAST) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One slice of the datapath.
    always_comb begin
        invert = is_sub(op_q);
        a_nib  = a_sh[SLICE-1:0];
        b_nib  = invert ? ~b_sh[SLICE-1:0] : b_sh[SLICE-1:0];
        sum    = {1'b0, a_nib} + {1'b0, b_nib} + {{SLICE{1'b0}}, carry};
        c_next = sum[SLICE];
        case (op_q)
            OP_ADD, OP_SUB, OP_SLT, OP_SLTU: nib_res = sum[SLICE-1:0];
            OP_AND:  nib_res = a_nib & b_nib;
            OP_OR:   nib_res = a_nib | b_nib;
            OP_XOR:  nib_res = a_nib ^ b_nib;
            default: nib_res = '0;
        endcase
        sh_next = {nib_res, res_sh[WIDTH-1:SLICE]};
    end

    // Final result, valid on the last EXEC edge when sh_next is complete.
    always_comb begin
        n_bit   = sh_next[WIDTH-1];
        v_bit   = (a_msb != b_msb) && (n_bit != a_msb);
        fin     = '0;
        fin_err = 1'b0;
        case (op_q)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: fin = sh_next;
            OP_SLT:  fin = {{(WIDTH-1){1'b0}}, n_bit ^ v_bit};
            OP_SLTU: fin = {{(WIDTH-1){1'b0}}, ~c_next};
            default: fin_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            op_q   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            res_q  <= '0;
            zero_q <= 1'b0;
            err_q  <= 1'b0;
        end else if (fire) begin
            a_sh   <= A;
            b_sh   <= B;
            res_sh <= '0;
            op_q   <= ALUControl;
            carry  <= is_sub(ALUControl);
            cnt    <= '0;
            a_msb  <= A[WIDTH-1];
            b_msb  <= B[WIDTH-1];
        end else if (state == EXEC) begin
            a_sh   <= a_sh >> SLICE;
            b_sh   <= b_sh >> SLICE;
            res_sh <= sh_next;
            carry  <= c_next;
            cnt    <= cnt + CW'(1);
            if (last) begin
                res_q  <= fin;
                zero_q <= (fin == '0);
                err_q  <= fin_err;
            end
        end
    end

endmodule

// File: tb/tb_alu_nibble_serial_exec.sv
// Directed bench for alu_nibble_serial_exec.
// Each scenario task checks its own outputs against hand-computed values.
module tb_alu_nibble_serial_exec;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  ALUControl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Result;
    logic        Zero;
    logic        Err;

    int checks = 0;
    int errors = 0;

    alu_nibble_serial_exec dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .A(A),
        .B(B),
        .ALUControl(ALUControl),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Result(Result),
        .Zero(Zero),
        .Err(Err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one request; returns 1 time unit after the accepting edge.
    // Operands are scrambled afterwards to prove they were latched.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] op);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        A = a;
        B = b;
        ALUControl = op;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A = 32'hDEADBEEF;
        B = 32'h13579BDF;
        ALUControl = 4'b1110;
    endtask

    // Edges counted from acceptance until out_valid (bounded).
    task automatic wait_done(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs in_ready=%b out_valid=%b want 1 0",
                     in_ready, out_valid);
        end
        checks++;
        if (Result !== 32'h0 || Zero !== 1'b0 || Err !== 1'b0) begin
            errors++;
            $display("FAIL reset_out R=%h Z=%b E=%b want 0 0 0",
                     Result, Zero, Err);
        end
    endtask

    task automatic test_add_carry();
        int n;
        start_op(32'hFFFFFFFF, 32'h00000001, 4'b0000);
        wait_done(n);
        checks++;
        if (n !== 8) begin
            errors++;
            $display("FAIL add_latency got %0d want 8", n);
        end
        checks++;
        if (Result !== 32'h0 || Zero !== 1'b1 || Err !== 1'b0) begin
            errors++;
            $display("FAIL add_wrap R=%h Z=%b E=%b want 0 1 0",
                     Result, Zero, Err);
        end
        release_out();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL add_release ov=%b ir=%b want 0 1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_sub();
        int n;
        start_op(32'd5, 32'd7, 4'b0001);
        wait_done(n);
        checks++;
        if (n !== 8 || Result !== 32'hFFFFFFFE || Zero !== 1'b0) begin
            errors++;
            $display("FAIL sub_neg n=%0d R=%h Z=%b want 8 fffffffe 0",
                     n, Result, Zero);
        end
        release_out();
        start_op(32'h12345678, 32'h12345678, 4'b0001);
        wait_done(n);
        checks++;
        if (Result !== 32'h0 || Zero !== 1'b1) begin
            errors++;
            $display("FAIL sub_eq R=%h Z=%b want 0 1", Result, Zero);
        end
        release_out();
        start_op(32'h00010000, 32'h00000001, 4'b0001);
        wait_done(n);
        checks++;
        if (Result !== 32'h0000FFFF) begin
            errors++;
            $display("FAIL sub_borrow R=%h want 0000ffff", Result);
        end
        release_out();
    endtask

    task automatic test_compare();
        int n;
        start_op(32'hFFFFFFFF, 32'h00000001, 4'b0101);
        wait_done(n);
        checks++;
        if (Result !== 32'h1 || Zero !== 1'b0) begin
            errors++;
            $display("FAIL slt_neg R=%h Z=%b want 1 0", Result, Zero);
        end
        release_out();
        start_op(32'hFFFFFFFF, 32'h00000001, 4'b0110);
        wait_done(n);
        checks++;
        if (Result !== 32'h0 || Zero !== 1'b1) begin
            errors++;
            $display("FAIL sltu R=%h Z=%b want 0 1", Result, Zero);
        end
        release_out();
        start_op(32'h80000000, 32'h7FFFFFFF, 4'b0101);
        wait_done(n);
        checks++;
        if (Result !== 32'h1) begin
            errors++;
            $display("FAIL slt_ovf R=%h want 1", Result);
        end
        release_out();
        start_op(32'h00000001, 32'hFFFFFFFF, 4'b0110);
        wait_done(n);
        checks++;
        if (Result !== 32'h1) begin
            errors++;
            $display("FAIL sltu_lt R=%h want 1", Result);
        end
        release_out();
    endtask

    task automatic test_logic();
        int n;
        start_op(32'hF0F01234, 32'h0FF0FFFF, 4'b0010);
        wait_done(n);
        checks++;
        if (Result !== 32'h00F01234) begin
            errors++;
            $display("FAIL and R=%h want 00f01234", Result);
        end
        release_out();
        start_op(32'hF0000000, 32'h0000000F, 4'b0011);
        wait_done(n);
        checks++;
        if (Result !== 32'hF000000F) begin
            errors++;
            $display("FAIL or R=%h want f000000f", Result);
        end
        release_out();
    endtask

    task automatic test_xor_backpressure();
        int n;
        start_op(32'hA5A5A5A5, 32'hFFFF0000, 4'b0100);
        wait_done(n);
        in_valid = 1'b1;
        A = 32'h1;
        B = 32'h1;
        ALUControl = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (Result !== 32'h5A5AA5A5 || out_valid !== 1'b1 ||
                in_ready !== 1'b0 || Zero !== 1'b0) begin
                errors++;
                $display("FAIL xor_hold[%0d] R=%h ov=%b ir=%b want 5a5aa5a5 1 0",
                         i, Result, out_valid, in_ready);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        release_out();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
            Result !== 32'h5A5AA5A5) begin
            errors++;
            $display("FAIL xor_release ov=%b ir=%b R=%h want 0 1 5a5aa5a5",
                     out_valid, in_ready, Result);
        end
    endtask

    task automatic test_err();
        int n;
        start_op(32'h12345678, 32'h9ABCDEF0, 4'b1111);
        wait_done(n);
        checks++;
        if (n !== 8 || Err !== 1'b1 || Result !== 32'h0 || Zero !== 1'b1) begin
            errors++;
            $display("FAIL err_op n=%0d E=%b R=%h Z=%b want 8 1 0 1",
                     n, Err, Result, Zero);
        end
        release_out();
        checks++;
        if (Err !== 1'b0) begin
            errors++;
            $display("FAIL err_drop E=%b want 0", Err);
        end
    endtask

    task automatic test_reset_midop();
        int n;
        start_op(32'hFFFFFFFF, 32'h00000001, 4'b0000);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || Result !== 32'h0 ||
            Zero !== 1'b0 || Err !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid ov=%b R=%h Z=%b E=%b want 0 0 0 0",
                     out_valid, Result, Zero, Err);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_abort ov=%b ir=%b want 0 1",
                     out_valid, in_ready);
        end
        start_op(32'd3, 32'd4, 4'b0000);
        wait_done(n);
        checks++;
        if (n !== 8 || Result !== 32'd7 || Zero !== 1'b0 || Err !== 1'b0) begin
            errors++;
            $display("FAIL rst_new n=%0d R=%h Z=%b E=%b want 8 7 0 0",
                     n, Result, Zero, Err);
        end
        release_out();
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        A = '0;
        B = '0;
        ALUControl = '0;
        test_reset();
        test_add_carry();
        test_sub();
        test_compare();
        test_logic();
        test_xor_backpressure();
        test_err();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
